// File: rtl/ccm_banked_dual_port.sv
// Banked dual-port CCM: interleaved banks, two request ports, A-priority arbitration with B anti-starvation.
// Reads return one cycle after acceptance; ready is the combinational grant and there is no response backpressure.
module ccm_banked_dual_port #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 1024,
    parameter int NUM_BANKS  = 4,
    parameter int STARVE_MAX = 3,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int BE_W      = DATA_W / 8
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 clk_override,

    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 a_we,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_wdata,
    input  logic [BE_W-1:0]      a_wstrb,
    output logic                 a_rvalid,
    output logic [DATA_W-1:0]    a_rdata,

    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic                 b_we,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_wdata,
    input  logic [BE_W-1:0]      b_wstrb,
    output logic                 b_rvalid,
    output logic [DATA_W-1:0]    b_rdata,

    output logic [NUM_BANKS-1:0] bank_clken
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BB        = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int ROW_W     = ADDR_W - BANK_BITS;
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int CNT_W     = $clog2(STARVE_MAX + 1);

    logic [BB-1:0]    a_bank, b_bank;
    logic [ROW_W-1:0] a_row, b_row;

    generate
        if (BANK_BITS == 0) begin : g_one_bank
            assign a_bank = '0;
            assign b_bank = '0;
        end else begin : g_multi_bank
            assign a_bank = a_addr[BANK_BITS-1:0];
            assign b_bank = b_addr[BANK_BITS-1:0];
        end
    endgenerate

    assign a_row = a_addr[ADDR_W-1:BANK_BITS];
    assign b_row = b_addr[ADDR_W-1:BANK_BITS];

    logic [CNT_W-1:0] starve_cnt;
    logic             conflict;
    logic             b_turn;
    logic             a_grant, b_grant;

    assign conflict = a_valid && b_valid && (a_bank == b_bank);
    assign b_turn   = (starve_cnt == CNT_W'(STARVE_MAX));
    assign a_grant  = rst_l && a_valid && (!conflict || !b_turn);
    assign b_grant  = rst_l && b_valid && (!conflict || b_turn);
    assign a_ready  = a_grant;
    assign b_ready  = b_grant;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            starve_cnt <= '0;
        end else if (b_grant) begin
            starve_cnt <= '0;
        end else if (conflict && !b_turn) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    logic [NUM_BANKS-1:0] sel_a, sel_b;
    logic [DATA_W-1:0]    bank_q [NUM_BANKS];

    // Arbitration guarantees sel_a and sel_b are never both set for one bank.
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] rd_q;
        logic              en;
        logic              we;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   wstrb;

        assign sel_a[i] = a_grant && (a_bank == BB'(i));
        assign sel_b[i] = b_grant && (b_bank == BB'(i));
        assign en       = sel_a[i] | sel_b[i];
        assign we       = sel_a[i] ? a_we    : b_we;
        assign row      = sel_a[i] ? a_row   : b_row;
        assign wdata    = sel_a[i] ? a_wdata : b_wdata;
        assign wstrb    = sel_a[i] ? a_wstrb : b_wstrb;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    for (int k = 0; k < BE_W; k++) begin
                        if (wstrb[k]) begin
                            mem[row][k*8 +: 8] <= wdata[k*8 +: 8];
                        end
                    end
                end else begin
                    rd_q <= mem[row];
                end
            end
        end

        assign bank_q[i]     = rd_q;
        assign bank_clken[i] = clk_override | en;
    end

    logic              a_rv_q, b_rv_q;
    logic [BB-1:0]     a_bank_q, b_bank_q;
    logic [DATA_W-1:0] a_hold, b_hold;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            a_rv_q <= 1'b0;
            b_rv_q <= 1'b0;
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            a_rv_q <= a_grant && !a_we;
            b_rv_q <= b_grant && !b_we;
            a_hold <= a_rdata;
            b_hold <= b_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (a_grant) a_bank_q <= a_bank;
        if (b_grant) b_bank_q <= b_bank;
    end

    // Reset gates the response immediately so an in-flight read is dropped in the reset cycle.
    assign a_rvalid = a_rv_q && rst_l;
    assign b_rvalid = b_rv_q && rst_l;
    assign a_rdata  = !rst_l ? '0 : (a_rv_q ? bank_q[a_bank_q] : a_hold);
    assign b_rdata  = !rst_l ? '0 : (b_rv_q ? bank_q[b_bank_q] : b_hold);

endmodule

// File: tb/tb_ccm_banked_dual_port.sv
// Scoreboard bench for ccm_banked_dual_port: word-level memory model, spec-level arbitration model.
module tb_ccm_banked_dual_port;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int NB = 4;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          clk_override = 1'b0;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [7:0]    a_wstrb = '0, b_wstrb = '0;
    logic          a_ready, b_ready, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [NB-1:0] bank_clken;

    ccm_banked_dual_port #(.DATA_W(DW), .DEPTH(1024), .NUM_BANKS(NB), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_l(rst_l), .clk_override(clk_override),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_wstrb(a_wstrb), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_wstrb(b_wstrb), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bank_clken(bank_clken)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem_m [1024];
    int            losses = 0;
    logic [DW-1:0] qa[$], qb[$];
    logic [DW-1:0] last_a = '0, last_b = '0;
    bit            mon_en = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rst_cycle();
        @(posedge clk);
        #1;
        rst_l = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        qa.delete();
        qb.delete();
        losses = 0;
        last_a = '0;
        last_b = '0;
        #2;
        chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
        chk("rst_b_ready", {63'd0, b_ready}, 64'd0);
        chk("rst_a_rvalid", {63'd0, a_rvalid}, 64'd0);
        chk("rst_b_rvalid", {63'd0, b_rvalid}, 64'd0);
        chk("rst_a_rdata", a_rdata, 64'd0);
        chk("rst_b_rdata", b_rdata, 64'd0);
    endtask

    task automatic step(input bit av, input bit awe, input int aad, input logic [DW-1:0] ad,
                        input logic [7:0] as, input bit bv, input bit bwe, input int bad,
                        input logic [DW-1:0] bd, input logic [7:0] bs, input bit ovr);
        bit            conf, ga, gb;
        logic [NB-1:0] exp_ck;
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        a_valid = av; a_we = awe; a_addr = AW'(aad); a_wdata = ad; a_wstrb = as;
        b_valid = bv; b_we = bwe; b_addr = AW'(bad); b_wdata = bd; b_wstrb = bs;
        clk_override = ovr;
        #2;
        conf = av && bv && ((aad % NB) == (bad % NB));
        ga = av && (!conf || losses != SM);
        gb = bv && (!conf || losses == SM);
        chk("a_ready", {63'd0, a_ready}, {63'd0, ga});
        chk("b_ready", {63'd0, b_ready}, {63'd0, gb});
        exp_ck = '0;
        if (ga) exp_ck[aad % NB] = 1'b1;
        if (gb) exp_ck[bad % NB] = 1'b1;
        if (ovr) exp_ck = '1;
        chk("bank_clken", {60'd0, bank_clken}, {60'd0, exp_ck});
        if (ga && !awe) qa.push_back(mem_m[aad]);
        if (gb && !bwe) qb.push_back(mem_m[bad]);
        for (int k = 0; k < 8; k++) begin
            if (ga && awe && as[k]) mem_m[aad][k*8 +: 8] = ad[k*8 +: 8];
            if (gb && bwe && bs[k]) mem_m[bad][k*8 +: 8] = bd[k*8 +: 8];
        end
        if (gb) losses = 0;
        else if (bv && conf && losses < SM) losses++;
    endtask

    task automatic idle();
        step(0, 0, 0, 64'd0, 8'd0, 0, 0, 0, 64'd0, 8'd0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_rvalid === 1'b1) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_rvalid: got rdata %h expected no response", a_rdata);
                end else begin
                    logic [DW-1:0] e;
                    e = qa.pop_front();
                    chk("a_rdata", a_rdata, e);
                    last_a = e;
                end
            end else begin
                chk("a_rdata_hold", a_rdata, last_a);
            end
            if (b_rvalid === 1'b1) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_rvalid: got rdata %h expected no response", b_rdata);
                end else begin
                    logic [DW-1:0] e;
                    e = qb.pop_front();
                    chk("b_rdata", b_rdata, e);
                    last_b = e;
                end
            end else begin
                chk("b_rdata_hold", b_rdata, last_b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mon_en = 1'b1;
        rst_cycle();
        rst_cycle();

        for (int i = 0; i < 64; i += 2)
            step(1, 1, i, {$urandom, $urandom}, 8'hFF, 1, 1, i + 1, {$urandom, $urandom}, 8'hFF, 0);

        step(1, 1, 5, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0, 64'd0, 8'd0, 0);
        step(1, 0, 5, 64'd0, 8'd0, 0, 0, 0, 64'd0, 8'd0, 0);
        step(1, 1, 5, 64'hFFFFFFFFFFFFFFFF, 8'h01, 0, 0, 0, 64'd0, 8'd0, 0);
        step(1, 0, 5, 64'd0, 8'd0, 0, 0, 0, 64'd0, 8'd0, 0);
        step(1, 1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h00, 0, 0, 0, 64'd0, 8'd0, 0);
        step(1, 0, 5, 64'd0, 8'd0, 0, 0, 0, 64'd0, 8'd0, 0);

        step(1, 0, 4, 64'd0, 8'd0, 1, 0, 9, 64'd0, 8'd0, 0);
        chk("par_clken", {60'd0, bank_clken}, 64'h3);
        chk("par_ready", {62'd0, a_ready, b_ready}, 64'h3);
        idle();

        for (int k = 0; k < 12; k++) begin
            step(1, 0, 0, 64'd0, 8'd0, 1, 0, 8, 64'd0, 8'd0, 0);
            chk($sformatf("starve_b_ready_%0d", k), {63'd0, b_ready}, {63'd0, (k % 4) == 3});
        end
        idle();

        step(1, 1, 7, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 0, 0, 64'd0, 8'd0, 0);
        step(1, 0, 7, 64'd0, 8'd0, 0, 0, 0, 64'd0, 8'd0, 0);
        rst_cycle();
        rst_cycle();
        step(1, 0, 7, 64'd0, 8'd0, 1, 0, 5, 64'd0, 8'd0, 0);
        idle();

        for (int n = 0; n < 500; n++) begin
            step(($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 15), {$urandom, $urandom},
                 8'($urandom), ($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 15),
                 {$urandom, $urandom}, 8'($urandom), ($urandom % 8) == 0);
        end

        idle();
        idle();
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
